// File: rtl/serial_add_sub.sv
// Digit-serial adder/subtractor: WIDTH-bit a +/- b computed DIGIT bits per clock, LSB first,
// with carry/borrow and signed overflow flags under a start/done handshake.
module serial_add_sub #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             overflow
);

   localparam int unsigned Steps = (DIGIT == 0) ? 1 : WIDTH / DIGIT;
   localparam int unsigned CntW  = (Steps > 1) ? $clog2(Steps) : 1;

   if (WIDTH < 2 || DIGIT == 0 || (WIDTH % DIGIT) != 0) begin : g_bad_param
      $error("serial_add_sub: WIDTH must be >= 2 and a multiple of DIGIT");
   end

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e                 state_q;
   logic [WIDTH-1:0]       a_q, b_q, res_q;
   logic                   cy_q;
   logic [CntW-1:0]        cnt_q;

   logic [DIGIT-1:0]       a_dig, b_dig, d_sum;
   logic                   d_cout, d_ovf, last_step;
   logic [WIDTH+DIGIT-1:0] res_cat;

   assign a_dig = a_q[DIGIT-1:0];
   assign b_dig = b_q[DIGIT-1:0];
   assign {d_cout, d_sum} = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, cy_q};
   // Result digits enter from the MSB side so the LSB digit ends up at bit 0.
   assign res_cat = {d_sum, res_q};
   // On the final digit, equal operand signs with a differing result sign is cin(MSB) ^ cout(MSB).
   assign d_ovf = (a_dig[DIGIT-1] == b_dig[DIGIT-1]) && (d_sum[DIGIT-1] != a_dig[DIGIT-1]);
   assign last_step = (cnt_q == CntW'(Steps - 1));

   assign ready = (state_q != StRun);
   assign busy  = (state_q == StRun);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         a_q      <= '0;
         b_q      <= '0;
         res_q    <= '0;
         cy_q     <= 1'b0;
         cnt_q    <= '0;
         done     <= 1'b0;
         sum      <= '0;
         carry    <= 1'b0;
         overflow <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state_q)
            StIdle, StDone: begin
               if (start) begin
                  a_q     <= a;
                  b_q     <= mode ? ~b : b;
                  cy_q    <= mode;
                  cnt_q   <= '0;
                  state_q <= StRun;
               end else begin
                  state_q <= StIdle;
               end
            end
            StRun: begin
               a_q   <= a_q >> DIGIT;
               b_q   <= b_q >> DIGIT;
               res_q <= res_cat[WIDTH+DIGIT-1:DIGIT];
               cy_q  <= d_cout;
               cnt_q <= cnt_q + CntW'(1);
               if (last_step) begin
                  state_q  <= StDone;
                  done     <= 1'b1;
                  sum      <= res_cat[WIDTH+DIGIT-1:DIGIT];
                  carry    <= d_cout;
                  overflow <= d_ovf;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_add_sub.sv
// Scoreboard bench for serial_add_sub: an 8-bit/1-bit-digit instance and a 16-bit/4-bit-digit
// instance, expected results queued at issue and popped on each done pulse.
module tb_serial_add_sub;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        s8_start, s8_mode;
   logic [7:0]  s8_a, s8_b, r8_sum;
   logic        r8_ready, r8_busy, r8_done, r8_carry, r8_ovf;

   logic        s16_start, s16_mode;
   logic [15:0] s16_a, s16_b, r16_sum;
   logic        r16_ready, r16_busy, r16_done, r16_carry, r16_ovf;

   int n_vec = 0;
   int n_bad = 0;
   logic [17:0] q8[$];
   logic [17:0] q16[$];

   serial_add_sub #(.WIDTH(8), .DIGIT(1)) u_dut8 (
      .clk(clk), .rst(rst), .start(s8_start), .mode(s8_mode), .a(s8_a), .b(s8_b),
      .ready(r8_ready), .busy(r8_busy), .done(r8_done), .sum(r8_sum), .carry(r8_carry),
      .overflow(r8_ovf)
   );

   serial_add_sub #(.WIDTH(16), .DIGIT(4)) u_dut16 (
      .clk(clk), .rst(rst), .start(s16_start), .mode(s16_mode), .a(s16_a), .b(s16_b),
      .ready(r16_ready), .busy(r16_busy), .done(r16_done), .sum(r16_sum), .carry(r16_carry),
      .overflow(r16_ovf)
   );

   // Reference: {overflow, carry, sum[15:0]} from integer arithmetic on w-bit operands.
   function automatic logic [17:0] model(input int w, input logic m, input logic [15:0] x,
                                         input logic [15:0] y);
      longint ux, uy, sx, sy, rs, full, lim;
      logic c, v;
      logic [15:0] s;
      lim = longint'(1) << w;
      ux = longint'(x);
      uy = longint'(y);
      sx = x[w-1] ? ux - lim : ux;
      sy = y[w-1] ? uy - lim : uy;
      if (m) begin
         full = ux - uy;
         c = (ux >= uy);
         rs = sx - sy;
      end else begin
         full = ux + uy;
         c = (full >= lim);
         rs = sx + sy;
      end
      full = full & (lim - 1);
      s = 16'(full);
      v = (rs >= lim / 2) || (rs < -(lim / 2));
      return {v, c, s};
   endfunction

   task automatic issue8(input logic m, input logic [7:0] x, input logic [7:0] y);
      s8_mode = m; s8_a = x; s8_b = y; s8_start = 1'b1;
      q8.push_back(model(8, m, {8'h00, x}, {8'h00, y}));
   endtask

   task automatic issue16(input logic m, input logic [15:0] x, input logic [15:0] y);
      s16_mode = m; s16_a = x; s16_b = y; s16_start = 1'b1;
      q16.push_back(model(16, m, x, y));
   endtask

   // Iteration 0 samples just after the accept edge; returns edges to done, or -1.
   task automatic wait_done8(output int cyc, output int bc);
      cyc = -1; bc = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (i == 0) s8_start = 1'b0;
         if (r8_busy) bc++;
         if (r8_done) begin cyc = i; break; end
      end
   endtask

   task automatic wait_done16(output int cyc);
      cyc = -1;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (i == 0) s16_start = 1'b0;
         if (r16_done) begin cyc = i; break; end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_vec++;
      if ({r8_ready, r8_busy, r8_done, r8_carry, r8_ovf, r8_sum} !== {5'b10000, 8'h00}) begin
         n_bad++;
         $display("FAIL reset8 got rdy/bsy/dn/c/v=%b%b%b%b%b sum=%h want 10000 sum=00",
                  r8_ready, r8_busy, r8_done, r8_carry, r8_ovf, r8_sum);
      end
      n_vec++;
      if ({r16_ready, r16_busy, r16_done, r16_carry, r16_ovf, r16_sum} !== {5'b10000, 16'h0}) begin
         n_bad++;
         $display("FAIL reset16 got rdy/bsy/dn/c/v=%b%b%b%b%b sum=%h want 10000 sum=0000",
                  r16_ready, r16_busy, r16_done, r16_carry, r16_ovf, r16_sum);
      end
      rst = 1'b0;
   endtask

   task automatic test_basic8;
      logic       modes[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      logic [7:0] as[5]    = '{8'h0F, 8'hFF, 8'h7F, 8'h05, 8'h80};
      logic [7:0] bs[5]    = '{8'h01, 8'h01, 8'h01, 8'h07, 8'h01};
      logic [17:0] e;
      int cyc, bc;
      for (int k = 0; k < 5; k++) begin
         issue8(modes[k], as[k], bs[k]);
         wait_done8(cyc, bc);
         e = q8.pop_front();
         n_vec++;
         if (cyc != 8) begin
            n_bad++; $display("FAIL latency8[%0d] got %0d want 8", k, cyc);
         end
         n_vec++;
         if (bc != 8) begin
            n_bad++; $display("FAIL busy_cycles8[%0d] got %0d want 8", k, bc);
         end
         n_vec++;
         if ({r8_ovf, r8_carry, r8_sum} !== {e[17], e[16], e[7:0]}) begin
            n_bad++;
            $display("FAIL result8[%0d] got v=%b c=%b sum=%h want v=%b c=%b sum=%h", k, r8_ovf,
                     r8_carry, r8_sum, e[17], e[16], e[7:0]);
         end
         @(posedge clk); #1;
         n_vec++;
         if ({r8_done, r8_ready} !== 2'b01) begin
            n_bad++; $display("FAIL done_pulse8[%0d] got done=%b ready=%b want 0 1", k, r8_done,
                              r8_ready);
         end
      end
   endtask

   task automatic test_back_to_back;
      logic [17:0] e;
      int t1 = -1, t2 = -1, bad_rdy = 0, nres = 0;
      issue8(1'b0, 8'h10, 8'h20);
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (i == 0) begin
            s8_a = 8'h01; s8_b = 8'h01;
            q8.push_back(model(8, 1'b0, 16'h0001, 16'h0001));
         end
         if (r8_ready && !r8_done) bad_rdy++;
         if (r8_done) begin
            e = q8.pop_front();
            n_vec++;
            if ({r8_ovf, r8_carry, r8_sum} !== {e[17], e[16], e[7:0]}) begin
               n_bad++;
               $display("FAIL b2b_result[%0d] got sum=%h c=%b v=%b want sum=%h c=%b v=%b", nres,
                        r8_sum, r8_carry, r8_ovf, e[7:0], e[16], e[17]);
            end
            nres++;
            if (t1 < 0) t1 = i;
            else begin t2 = i; s8_start = 1'b0; break; end
         end
      end
      s8_start = 1'b0;
      n_vec++;
      if (t1 != 8 || t2 - t1 != 9) begin
         n_bad++; $display("FAIL b2b_spacing got t1=%0d gap=%0d want t1=8 gap=9", t1, t2 - t1);
      end
      n_vec++;
      if (bad_rdy != 0) begin
         n_bad++; $display("FAIL b2b_ready got %0d ready-high non-done cycles want 0", bad_rdy);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_ignore_mid_run;
      logic [17:0] e;
      int ndone = 0;
      issue8(1'b0, 8'h33, 8'h11);
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         if (i == 0) s8_start = 1'b0;
         if (i == 3) begin
            s8_start = 1'b1; s8_mode = 1'b1; s8_a = 8'h99; s8_b = 8'h22;
         end
         if (i == 4) s8_start = 1'b0;
         if (r8_done) begin
            ndone++;
            if (q8.size() > 0) begin
               e = q8.pop_front();
               n_vec++;
               if ({r8_ovf, r8_carry, r8_sum} !== {e[17], e[16], e[7:0]}) begin
                  n_bad++;
                  $display("FAIL ignore_result got sum=%h c=%b v=%b want sum=%h c=%b v=%b",
                           r8_sum, r8_carry, r8_ovf, e[7:0], e[16], e[17]);
               end
            end
         end
      end
      n_vec++;
      if (ndone != 1) begin
         n_bad++; $display("FAIL ignore_done_count got %0d want 1", ndone);
      end
   endtask

   task automatic test_reset_mid_run;
      logic [17:0] e;
      int ndone = 0, cyc, bc;
      issue8(1'b1, 8'h50, 8'h20);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (i == 0) s8_start = 1'b0;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      q8.delete();
      n_vec++;
      if ({r8_ready, r8_busy, r8_done, r8_carry, r8_ovf, r8_sum} !== {5'b10000, 8'h00}) begin
         n_bad++;
         $display("FAIL midrun_reset got rdy/bsy/dn/c/v=%b%b%b%b%b sum=%h want 10000 sum=00",
                  r8_ready, r8_busy, r8_done, r8_carry, r8_ovf, r8_sum);
      end
      for (int i = 0; i < 12; i++) begin
         if (r8_done) ndone++;
         @(posedge clk); #1;
      end
      n_vec++;
      if (ndone != 0) begin
         n_bad++; $display("FAIL midrun_no_done got %0d done pulses want 0", ndone);
      end
      issue8(1'b1, 8'h50, 8'h20);
      wait_done8(cyc, bc);
      e = q8.pop_front();
      n_vec++;
      if (cyc != 8 || {r8_ovf, r8_carry, r8_sum} !== {e[17], e[16], e[7:0]}) begin
         n_bad++;
         $display("FAIL after_reset_op got lat=%0d sum=%h c=%b v=%b want lat=8 sum=%h c=%b v=%b",
                  cyc, r8_sum, r8_carry, r8_ovf, e[7:0], e[16], e[17]);
      end
   endtask

   task automatic test_wide16;
      logic [17:0] e;
      int cyc;
      issue16(1'b1, 16'h1234, 16'h0235);
      wait_done16(cyc);
      e = q16.pop_front();
      n_vec++;
      if (cyc != 4) begin
         n_bad++; $display("FAIL latency16 got %0d want 4", cyc);
      end
      n_vec++;
      if ({r16_ovf, r16_carry, r16_sum} !== {2'b01, 16'h0FFF}) begin
         n_bad++; $display("FAIL sub16_const got v=%b c=%b sum=%h want v=0 c=1 sum=0fff",
                           r16_ovf, r16_carry, r16_sum);
      end
      n_vec++;
      if ({r16_ovf, r16_carry, r16_sum} !== e) begin
         n_bad++; $display("FAIL sub16_model got %h want %h", {r16_ovf, r16_carry, r16_sum}, e);
      end
   endtask

   task automatic test_random;
      logic [17:0] e;
      int cyc, bc;
      for (int k = 0; k < 2000; k++) begin
         issue16(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
         wait_done16(cyc);
         e = q16.pop_front();
         n_vec++;
         if (cyc != 4 || {r16_ovf, r16_carry, r16_sum} !== e) begin
            n_bad++;
            $display("FAIL rand16[%0d] mode=%b a=%h b=%h got lat=%0d res=%h want lat=4 res=%h",
                     k, s16_mode, s16_a, s16_b, cyc, {r16_ovf, r16_carry, r16_sum}, e);
         end
      end
      for (int k = 0; k < 300; k++) begin
         issue8(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
         wait_done8(cyc, bc);
         e = q8.pop_front();
         n_vec++;
         if (cyc != 8 || {r8_ovf, r8_carry, r8_sum} !== {e[17], e[16], e[7:0]}) begin
            n_bad++;
            $display("FAIL rand8[%0d] mode=%b a=%h b=%h got lat=%0d res=%h want lat=8 res=%h",
                     k, s8_mode, s8_a, s8_b, cyc, {r8_ovf, r8_carry, r8_sum},
                     {e[17], e[16], e[7:0]});
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      s8_start = 1'b0; s8_mode = 1'b0; s8_a = '0; s8_b = '0;
      s16_start = 1'b0; s16_mode = 1'b0; s16_a = '0; s16_b = '0;
      test_reset();
      test_basic8();
      test_back_to_back();
      test_ignore_mid_run();
      test_reset_mid_run();
      test_wide16();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
